// File: rtl/fmc_adc_ext_trig_cond.sv
// ---------------------------------------------------------------------------
// fmc_adc_ext_trig_cond
//
// Conditions the external trigger of the FMC ADC. The raw LVDS level is
// synchronised into sys_clk_i and polarity-corrected. Active edges are then
// glitch-filtered and delayed before a single-cycle trigger pulse is issued.
// Edges that arrive while a delay is running are counted as misses.
//
// Ports
//   sys_clk_i    : single clock for all logic
//   sys_rst_n_i  : synchronous, active-low reset
//   ext_trig_i   : raw external trigger level (asynchronous)
//   en_i         : enable; low forces IDLE and freezes the miss counter
//   pol_i        : active edge select (0 = rising, 1 = falling)
//   filt_len_i   : cycles the level must stay active after the edge
//   dly_i        : delay in cycles from qualification to trigger
//   clr_miss_i   : single-cycle clear of the miss counter
//   trig_o       : single-cycle trigger pulse (registered)
//   busy_o       : high while filtering or delaying (registered)
//   miss_cnt_o   : saturating count of edges ignored during the delay
// ---------------------------------------------------------------------------
module fmc_adc_ext_trig_cond #(
  parameter int unsigned g_filt_width = 8,
  parameter int unsigned g_dly_width  = 32,
  parameter int unsigned g_miss_width = 16
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_n_i,
  input  logic                    ext_trig_i,
  input  logic                    en_i,
  input  logic                    pol_i,
  input  logic [g_filt_width-1:0] filt_len_i,
  input  logic [g_dly_width-1:0]  dly_i,
  input  logic                    clr_miss_i,
  output logic                    trig_o,
  output logic                    busy_o,
  output logic [g_miss_width-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_DELAY  = 2'd2
  } state_t;

  localparam logic [g_dly_width-1:0]  c_cnt_one  = {{(g_dly_width-1){1'b0}}, 1'b1};
  localparam logic [g_miss_width-1:0] c_miss_one = {{(g_miss_width-1){1'b0}}, 1'b1};
  localparam logic [g_miss_width-1:0] c_miss_max = {g_miss_width{1'b1}};

  // Synchroniser, edge history and FSM registers
  logic                    sync1_q, sync2_q;
  logic                    lvl_q;
  state_t                  state_q, state_d;
  logic [g_dly_width-1:0]  cnt_q, cnt_d;
  logic [g_dly_width-1:0]  filt_q, filt_d;
  logic [g_dly_width-1:0]  dly_q, dly_d;
  logic                    trig_q, trig_d;
  logic                    busy_q, busy_d;
  logic [g_miss_width-1:0] miss_q, miss_d;

  // Active level and edge in the current cycle
  logic lvl_s;
  logic edge_s;

  // Polarity-corrected level and its rising edge (edge = active edge)
  always_comb begin
    lvl_s  = sync2_q ^ pol_i;
    edge_s = lvl_s & ~lvl_q;
  end

  // Next-state logic for the trigger FSM, latched settings and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    dly_d   = dly_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (edge_s) begin
            // Settings are captured here so later CSR writes cannot disturb
            // a trigger that is already under way.
            state_d = ST_FILTER;
            cnt_d   = '0;
            filt_d  = g_dly_width'(filt_len_i);
            dly_d   = dly_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FILTER: begin
          // Reaching the terminal count qualifies the edge even if the level
          // drops in that same cycle; a length of zero qualifies at once.
          if (cnt_q == filt_q) begin
            state_d = ST_DELAY;
            cnt_d   = '0;
          end else if (!lvl_s) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        ST_DELAY: begin
          if (cnt_q == dly_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output look-ahead: trig/busy are registered, so they are derived from the
  // state the FSM is about to enter rather than the one it is leaving.
  always_comb begin
    trig_d = (state_d == ST_DELAY) && (cnt_d == dly_d);
    busy_d = (state_d != ST_IDLE);
  end

  // Miss counter: clear wins, increments only for edges seen during DELAY
  always_comb begin
    if (clr_miss_i) begin
      miss_d = '0;
    end else if (en_i && (state_q == ST_DELAY) && edge_s && (miss_q != c_miss_max)) begin
      miss_d = miss_q + c_miss_one;
    end else begin
      miss_d = miss_q;
    end
  end

  // All state, including the synchroniser, with synchronous active-low reset
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      filt_q  <= '0;
      dly_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      sync1_q <= ext_trig_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      dly_q   <= dly_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      miss_q  <= miss_d;
    end
  end

  assign trig_o     = trig_q;
  assign busy_o     = busy_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_fmc_adc_ext_trig_cond.sv
// ---------------------------------------------------------------------------
// Testbench for fmc_adc_ext_trig_cond. A directed vector table, hand-written
// multi-cycle sequences and a randomised phase. A cycle-level reference model
// (edge time + arithmetic deadlines) checks every cycle. A second instance
// with a 4-bit miss counter exercises saturation in a short run.
// ---------------------------------------------------------------------------
module tb_fmc_adc_ext_trig_cond;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext;
  logic        en;
  logic        pol;
  logic [7:0]  fl;
  logic [31:0] dl;
  logic        clr;
  logic        trig, busy;
  logic [15:0] miss;
  logic        trig_n, busy_n;
  logic [3:0]  miss_n;

  always #5 clk = ~clk;

  fmc_adc_ext_trig_cond dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .ext_trig_i(ext), .en_i(en),
    .pol_i(pol), .filt_len_i(fl), .dly_i(dl), .clr_miss_i(clr),
    .trig_o(trig), .busy_o(busy), .miss_cnt_o(miss)
  );

  fmc_adc_ext_trig_cond #(.g_miss_width(4)) dut_n (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .ext_trig_i(ext), .en_i(en),
    .pol_i(pol), .filt_len_i(fl), .dly_i(dl), .clr_miss_i(clr),
    .trig_o(trig_n), .busy_o(busy_n), .miss_cnt_o(miss_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------- reference model -------------------------------
  // Abstract view: a trigger is described by its edge cycle and the cycle in
  // which it must fire; filtering is a window in which the level must hold.
  longint m_cyc = 0;
  logic   m_x1 = 1'b0, m_x2 = 1'b0, m_lvlq = 1'b0;
  logic   m_busy = 1'b0;
  longint m_start = 0, m_fire = 0;
  int     m_fl = 0;
  int     m_miss16 = 0, m_miss4 = 0;
  logic   m_exp_trig = 1'b0, m_exp_busy = 1'b0;
  logic   model_valid = 1'b0;

  always @(posedge clk) begin
    logic lvl, act_edge;
    if (!rst_n) begin
      m_x1 = 1'b0; m_x2 = 1'b0; m_lvlq = 1'b0; m_busy = 1'b0;
      m_miss16 = 0; m_miss4 = 0;
      m_exp_trig = 1'b0; m_exp_busy = 1'b0;
      model_valid = 1'b1;
    end else begin
      lvl      = m_x2 ^ pol;
      act_edge = lvl & ~m_lvlq;
      if (!en) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        if (act_edge && (m_cyc >= m_start + m_fl + 2)) begin
          if (m_miss16 < 65535) m_miss16++;
          if (m_miss4 < 15) m_miss4++;
        end
        if ((m_cyc < m_start + m_fl + 1) && !lvl) m_busy = 1'b0;
        else if (m_cyc == m_fire) m_busy = 1'b0;
      end else if (act_edge) begin
        m_start = m_cyc;
        m_fl    = int'(fl);
        m_fire  = m_cyc + longint'(fl) + longint'(dl) + 2;
        m_busy  = 1'b1;
      end
      if (clr) begin
        m_miss16 = 0;
        m_miss4  = 0;
      end
      m_exp_busy = m_busy;
      m_exp_trig = m_busy && (m_cyc + 1 == m_fire);
      m_x2   = m_x1;
      m_x1   = ext;
      m_lvlq = lvl;
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model trig_o", trig, m_exp_trig);
      check("model busy_o", busy, m_exp_busy);
      check("model miss_cnt_o", miss, m_miss16);
      check("model trig_o (4b)", trig_n, m_exp_trig);
      check("model busy_o (4b)", busy_n, m_exp_busy);
      check("model miss_cnt_o (4b)", miss_n, m_miss4);
    end
  end

  // ------------------------- directed vector table -------------------------
  typedef struct {
    logic p;
    int   f;
    int   d;
    int   glitches;  // 1-cycle-active / 1-cycle-idle pairs before the pulse
    int   hold;      // cycles the final pulse stays active
    int   exp_count; // trigger pulses in the window
    int   exp_lat;   // cycles from first active drive to trig_o
    int   exp_busy;  // total busy_o cycles in the window
  } vec_t;

  vec_t vecs[7];

  task automatic setup(input logic p, input int f, input int d);
    @(negedge clk);
    en = 1'b0; pol = p; ext = p; fl = 8'(f); dl = 32'(d); clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ntrig, tfirst, nbusy;
    logic act;
    ntrig = 0; tfirst = -1; nbusy = 0;
    setup(v.p, v.f, v.d);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (trig) begin
        if (ntrig == 0) tfirst = t;
        ntrig++;
      end
      if (busy) nbusy++;
      if (t < 2 * v.glitches) act = (t % 2 == 0);
      else act = (t < 2 * v.glitches + v.hold);
      ext = v.p ^ act;
    end
    check($sformatf("vec%0d trig count", idx), ntrig, v.exp_count);
    if (v.exp_count > 0) check($sformatf("vec%0d latency", idx), tfirst, v.exp_lat);
    check($sformatf("vec%0d busy cycles", idx), nbusy, v.exp_busy);
    check($sformatf("vec%0d miss", idx), miss, 0);
  endtask

  // ------------------------- main sequence ---------------------------------
  initial begin
    int ntrig, tfirst;

    vecs[0] = '{1'b0, 0, 0, 0, 10, 1,  4,  2};
    vecs[1] = '{1'b0, 4, 3, 2, 10, 1, 15, 11};
    vecs[2] = '{1'b1, 0, 5, 0,  8, 1,  9,  7};
    vecs[3] = '{1'b0, 2, 0, 0,  2, 0, -1,  2};
    vecs[4] = '{1'b0, 2, 0, 0,  3, 1,  6,  4};
    vecs[5] = '{1'b0, 0, 0, 0,  1, 1,  4,  2};
    vecs[6] = '{1'b1, 3, 2, 1,  6, 1, 11,  8};

    rst_n = 1'b0; ext = 1'b0; en = 1'b0; pol = 1'b0; fl = 8'd0; dl = 32'd0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset trig_o", trig, 0);
    check("reset busy_o", busy, 0);
    check("reset miss_cnt_o", miss, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Falling edges 20 cycles apart during a 100-cycle delay
    setup(1'b1, 0, 100);
    ntrig = 0; tfirst = -1;
    for (int t = 0; t < 140; t++) begin
      @(negedge clk);
      if (trig) begin if (ntrig == 0) tfirst = t; ntrig++; end
      ext = ~((t < 5) || (t >= 20 && t < 25));
    end
    check("long dly trig count", ntrig, 1);
    check("long dly latency", tfirst, 104);
    check("long dly miss", miss, 1);

    // Enable dropped mid-DELAY, then re-enabled with a fresh edge
    setup(1'b0, 0, 10);
    ntrig = 0; tfirst = -1;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (trig) begin if (ntrig == 0) tfirst = t; ntrig++; end
      if (t == 7) check("en drop busy before", busy, 1);
      if (t == 8) check("en drop busy after", busy, 0);
      ext = (t < 30) || (t >= 45 && t < 50);
      en  = !(t >= 7 && t < 12);
    end
    check("en drop trig count", ntrig, 1);
    check("en drop re-arm latency", tfirst, 59);

    // Edge storm during a long delay: saturation and clear-beats-increment
    setup(1'b0, 0, 300);
    ntrig = 0; tfirst = -1;
    for (int t = 0; t < 330; t++) begin
      @(negedge clk);
      if (trig) begin if (ntrig == 0) tfirst = t; ntrig++; end
      if (t == 40) begin
        check("storm miss before clr", miss, 18);
        check("storm miss 4b saturated", miss_n, 15);
      end
      if (t == 41) begin
        check("storm clr wins", miss, 0);
        check("storm clr wins 4b", miss_n, 0);
      end
      ext = (t < 120) ? (t % 2 == 0) : 1'b0;
      clr = (t == 40);
    end
    check("storm miss final", miss, 40);
    check("storm miss 4b final", miss_n, 15);
    check("storm trig count", ntrig, 1);
    check("storm latency", tfirst, 304);

    // One-cycle reset in the middle of DELAY
    setup(1'b0, 0, 20);
    ntrig = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (trig) ntrig++;
      if (t == 11) begin
        check("mid-delay reset trig", trig, 0);
        check("mid-delay reset busy", busy, 0);
        check("mid-delay reset miss", miss, 0);
      end
      ext   = (t < 3);
      rst_n = (t != 10);
    end
    check("mid-delay reset trig count", ntrig, 0);

    // Reset released with the level already active: exactly one trigger
    setup(1'b0, 0, 0);
    ntrig = 0; tfirst = -1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (trig) begin if (ntrig == 0) tfirst = t; ntrig++; end
      ext   = (t < 20);
      rst_n = (t >= 3);
    end
    check("post-reset edge trig count", ntrig, 1);
    check("post-reset edge latency", tfirst, 7);

    // Randomised phase; the per-cycle model does the checking
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) ext = ~ext;
      en    = ($urandom_range(0, 60) != 0);
      clr   = ($urandom_range(0, 50) == 0);
      fl    = 8'($urandom_range(0, 4));
      dl    = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 400) == 0) pol = ~pol;
      rst_n = ($urandom_range(0, 500) != 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
